// File: rtl/bpu_update_ctrl.sv
// Branch predictor training sequencer: mispredict redirect, buffered BTB update
// writes, and a full BTB invalidate sweep with RAS clear on flush request.
module bpu_update_ctrl #(
    parameter int DEPTH   = 4,
    parameter int ENTRIES = 64,
    parameter int IDXW    = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [31:0]     ex_pc,
    input  logic [2:0]      ex_type,
    input  logic            ex_taken,
    input  logic [31:0]     ex_target,
    input  logic            ex_pred_hit,
    input  logic            ex_pred_taken,
    input  logic [31:0]     ex_pred_pc,
    output logic            redirect,
    output logic [31:0]     redirect_pc,
    output logic            btb_we,
    input  logic            btb_wready,
    output logic [31:0]     btb_wpc,
    output logic [2:0]      btb_wtype,
    output logic            btb_wtaken,
    output logic [31:0]     btb_wtarget,
    output logic            btb_winv,
    output logic            btb_inv_all,
    output logic [IDXW-1:0] btb_inv_idx,
    output logic            ras_clr,
    input  logic            flush_req,
    output logic            flush_done
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  typ;
        logic        taken;
        logic [31:0] target;
        logic        inv;
    } upd_t;

    typedef enum logic [1:0] {IDLE, CLR, SWEEP, DONE} state_t;

    state_t          state;
    logic [IDXW-1:0] idx;
    upd_t            fifo_q [DEPTH];
    logic [PW:0]     wr_ptr, rd_ptr;
    logic            empty, full, accepted, mispredict, do_enq, pop;
    logic [31:0]     pc_plus4, pred_next, actual_next;
    upd_t            enq_entry, head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    assign ex_ready = !full && (state == IDLE);
    assign accepted = ex_valid && ex_ready;

    // A not-taken-predicted conditional branch falls through even on a BTB hit
    assign pc_plus4    = ex_pc + 32'd4;
    assign pred_next   = (ex_pred_hit && (ex_type != 3'b001 || ex_pred_taken)) ? ex_pred_pc : pc_plus4;
    assign actual_next = ex_taken ? ex_target : pc_plus4;
    assign mispredict  = accepted && (pred_next != actual_next);

    // A hit on a non-branch is an alias; it is queued as an invalidate
    assign do_enq = accepted && !flush_req && (ex_type != 3'b000 || ex_pred_hit);
    always_comb begin
        enq_entry = '0;
        enq_entry.pc = ex_pc;
        if (ex_type != 3'b000) begin
            enq_entry.typ    = ex_type;
            enq_entry.taken  = ex_taken;
            enq_entry.target = ex_target;
        end else begin
            enq_entry.inv = 1'b1;
        end
    end

    assign head   = fifo_q[rd_ptr[PW-1:0]];
    assign btb_we = !empty && (state == IDLE);
    assign pop    = btb_we && btb_wready;

    assign btb_wpc     = btb_we ? head.pc     : '0;
    assign btb_wtype   = btb_we ? head.typ    : '0;
    assign btb_wtaken  = btb_we && head.taken;
    assign btb_wtarget = btb_we ? head.target : '0;
    assign btb_winv    = btb_we && head.inv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
        end else if (state == IDLE && flush_req) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_enq) begin
                fifo_q[wr_ptr[PW-1:0]] <= enq_entry;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            redirect <= mispredict;
            if (mispredict) redirect_pc <= actual_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE:  if (flush_req) state <= CLR;
                CLR: begin
                    idx   <= '0;
                    state <= SWEEP;
                end
                SWEEP: if (btb_wready) begin
                    if (idx == IDXW'(ENTRIES - 1)) state <= DONE;
                    else idx <= idx + 1'b1;
                end
                DONE: begin
                    idx   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sweep-side outputs decode straight from the state register
    assign ras_clr     = (state == CLR);
    assign btb_inv_all = (state == SWEEP);
    assign btb_inv_idx = btb_inv_all ? idx : '0;
    assign flush_done  = (state == DONE);
endmodule

// File: tb/tb_bpu_update_ctrl.sv
// Directed bench for bpu_update_ctrl: vector table for single-branch training,
// plus backpressure, flush sweep and async-reset-mid-sweep sequences.
module tb_bpu_update_ctrl;
    logic        clk, rst;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_pc, ex_target, ex_pred_pc;
    logic [2:0]  ex_type;
    logic        ex_taken, ex_pred_hit, ex_pred_taken;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        btb_we, btb_wready;
    logic [31:0] btb_wpc, btb_wtarget;
    logic [2:0]  btb_wtype;
    logic        btb_wtaken, btb_winv, btb_inv_all;
    logic [5:0]  btb_inv_idx;
    logic        ras_clr, flush_req, flush_done;

    int n_vec = 0;
    int n_err = 0;

    bpu_update_ctrl #(.DEPTH(4), .ENTRIES(64)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_type(ex_type),
        .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_hit(ex_pred_hit),
        .ex_pred_taken(ex_pred_taken), .ex_pred_pc(ex_pred_pc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .btb_we(btb_we), .btb_wready(btb_wready), .btb_wpc(btb_wpc), .btb_wtype(btb_wtype),
        .btb_wtaken(btb_wtaken), .btb_wtarget(btb_wtarget), .btb_winv(btb_winv),
        .btb_inv_all(btb_inv_all), .btb_inv_idx(btb_inv_idx), .ras_clr(ras_clr),
        .flush_req(flush_req), .flush_done(flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [112:0] all_out;
    assign all_out = {ex_ready, redirect, redirect_pc, btb_we, btb_wpc, btb_wtype, btb_wtaken,
                      btb_wtarget, btb_winv, btb_inv_all, btb_inv_idx, ras_clr, flush_done};
    localparam logic [112:0] RST_OUT = {1'b1, 112'd0};

    typedef struct {
        logic [31:0] pc;  logic [2:0] typ; logic taken; logic [31:0] tgt;
        logic hit; logic ptaken; logic [31:0] ppc;
        logic redir; logic [31:0] rpc;
        logic we; logic [31:0] wpc; logic [2:0] wtype; logic wtaken; logic [31:0] wtgt; logic winv;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(logic [31:0] pc, logic [2:0] typ, logic taken, logic [31:0] tgt,
                                logic hit, logic ptaken, logic [31:0] ppc,
                                logic redir, logic [31:0] rpc, logic we, logic [31:0] wpc,
                                logic [2:0] wtype, logic wtaken, logic [31:0] wtgt, logic winv);
        vec_t v;
        v.pc = pc; v.typ = typ; v.taken = taken; v.tgt = tgt;
        v.hit = hit; v.ptaken = ptaken; v.ppc = ppc;
        v.redir = redir; v.rpc = rpc; v.we = we; v.wpc = wpc;
        v.wtype = wtype; v.wtaken = wtaken; v.wtgt = wtgt; v.winv = winv;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [2:0] typ, input logic taken,
                         input logic [31:0] tgt, input logic hit, input logic ptaken,
                         input logic [31:0] ppc);
        ex_valid = 1'b1; ex_pc = pc; ex_type = typ; ex_taken = taken; ex_target = tgt;
        ex_pred_hit = hit; ex_pred_taken = ptaken; ex_pred_pc = ppc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc, exp_idx;
        logic seen;
        //               pc            typ    tk tgt           hit pt ppc          rd rpc          we wpc           wty   wtk wtgt        inv
        vecs[0]  = mk(32'h100,      3'b010, 1, 32'h200,      0, 0, 32'h0,      1, 32'h200,  1, 32'h100,      3'b010, 1, 32'h200, 0);
        vecs[1]  = mk(32'h40,       3'b001, 1, 32'h80,       1, 1, 32'h80,     0, 32'h200,  1, 32'h40,       3'b001, 1, 32'h80,  0);
        vecs[2]  = mk(32'h10,       3'b000, 0, 32'h55,       1, 0, 32'h300,    1, 32'h14,   1, 32'h10,       3'b000, 0, 32'h0,   1);
        vecs[3]  = mk(32'h500,      3'b001, 0, 32'h600,      1, 0, 32'h900,    0, 32'h14,   1, 32'h500,      3'b001, 0, 32'h600, 0);
        vecs[4]  = mk(32'h700,      3'b001, 1, 32'h800,      1, 0, 32'h800,    1, 32'h800,  1, 32'h700,      3'b001, 1, 32'h800, 0);
        vecs[5]  = mk(32'h1000,     3'b011, 1, 32'h2000,     1, 0, 32'h2000,   0, 32'h800,  1, 32'h1000,     3'b011, 1, 32'h2000, 0);
        vecs[6]  = mk(32'h1200,     3'b101, 1, 32'h3400,     1, 1, 32'h3000,   1, 32'h3400, 1, 32'h1200,     3'b101, 1, 32'h3400, 0);
        vecs[7]  = mk(32'h20,       3'b000, 0, 32'h0,        0, 0, 32'h0,      0, 32'h3400, 0, 32'h0,        3'b000, 0, 32'h0,   0);
        vecs[8]  = mk(32'hFFFFFFFC, 3'b001, 0, 32'h0,        0, 0, 32'h0,      0, 32'h3400, 1, 32'hFFFFFFFC, 3'b001, 0, 32'h0,   0);
        vecs[9]  = mk(32'hFFFFFFFC, 3'b100, 1, 32'h40,       0, 0, 32'h0,      1, 32'h40,   1, 32'hFFFFFFFC, 3'b100, 1, 32'h40,  0);
        vecs[10] = mk(32'h60,       3'b110, 1, 32'h88,       1, 0, 32'h88,     0, 32'h40,   1, 32'h60,       3'b110, 1, 32'h88,  0);
        vecs[11] = mk(32'hFFFFFFFC, 3'b000, 0, 32'h123,      1, 0, 32'h0,      0, 32'h40,   1, 32'hFFFFFFFC, 3'b000, 0, 32'h0,   1);

        rst = 1'b1; ex_valid = 0; ex_pc = 0; ex_type = 0; ex_taken = 0; ex_target = 0;
        ex_pred_hit = 0; ex_pred_taken = 0; ex_pred_pc = 0; btb_wready = 1'b1; flush_req = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_state", all_out, RST_OUT);

        // single-branch training table
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].pc, vecs[i].typ, vecs[i].taken, vecs[i].tgt,
                  vecs[i].hit, vecs[i].ptaken, vecs[i].ppc);
            @(posedge clk); #1;
            ex_valid = 1'b0;
            chk($sformatf("vec%0d", i),
                {redirect, redirect_pc, btb_we, btb_wpc, btb_wtype, btb_wtaken, btb_wtarget, btb_winv},
                {vecs[i].redir, vecs[i].rpc, vecs[i].we, vecs[i].wpc, vecs[i].wtype,
                 vecs[i].wtaken, vecs[i].wtgt, vecs[i].winv});
            @(posedge clk); #1;
            chk($sformatf("vec%0d_clear", i), {redirect, btb_we}, 2'b00);
        end

        // backpressure: fill the FIFO, then drain in order
        btb_wready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_ready%0d", i), ex_ready, 1'b1);
            drive(32'hA00 + 32'(4 * i), 3'b001, 0, 32'h0, 0, 0, 32'h0);
            @(posedge clk); #1;
        end
        drive(32'hBBB0, 3'b010, 1, 32'h4000, 0, 0, 32'h0);
        chk("bp_full_notready", ex_ready, 1'b0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        chk("bp_held_notready", ex_ready, 1'b0);
        btb_wready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_write%0d", i), {btb_we, btb_wpc}, {1'b1, 32'hA00 + 32'(4 * i)});
            @(posedge clk); #1;
            if (i == 0) chk("bp_ready_after_pop", ex_ready, 1'b1);
        end
        chk("bp_drained", btb_we, 1'b0);

        // flush with two queued entries and a same-cycle mispredict
        btb_wready = 1'b0;
        drive(32'hC00, 3'b010, 1, 32'hD00, 0, 0, 32'h0);
        @(posedge clk); #1;
        drive(32'hC04, 3'b010, 1, 32'hD00, 0, 0, 32'h0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        chk("fl_queued", {btb_we, btb_wpc, ex_ready}, {1'b1, 32'hC00, 1'b1});
        drive(32'hE00, 3'b010, 1, 32'hE80, 0, 0, 32'h0);
        flush_req = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        chk("fl_redirect", {redirect, redirect_pc}, {1'b1, 32'hE80});
        chk("fl_clr", {ras_clr, btb_we, ex_ready, btb_inv_all}, 4'b1000);
        @(posedge clk); #1;
        cyc = 0; exp_idx = 0;
        while (btb_inv_all && cyc < 200) begin
            btb_wready = !(cyc == 10 || cyc == 11 || cyc == 30);
            chk($sformatf("sweep_c%0d", cyc), {btb_inv_idx, btb_we, ras_clr, flush_done},
                {6'(exp_idx), 3'b000});
            @(posedge clk); #1;
            if (btb_wready) exp_idx++;
            cyc++;
        end
        chk("sweep_len", 32'(cyc), 32'd67);
        chk("fl_done", {flush_done, btb_inv_all, btb_inv_idx}, {1'b1, 1'b0, 6'd0});
        flush_req = 1'b0;
        btb_wready = 1'b1;
        @(posedge clk); #1;
        chk("fl_idle_empty", {flush_done, btb_we, ex_ready, btb_inv_all}, 4'b0010);

        // async reset in the middle of a sweep
        flush_req = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        while (btb_inv_idx != 6'd20 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rs_reach_idx20", {btb_inv_all, btb_inv_idx}, {1'b1, 6'd20});
        #2 rst = 1'b1;
        #1 chk("rs_async", all_out, RST_OUT);
        flush_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            seen = seen | flush_done | btb_inv_all | ras_clr;
        end
        chk("rs_no_done", seen, 1'b0);
        chk("rs_idle", all_out, RST_OUT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bpu_update_ctrl.md
Name: bpu_update_ctrl

Overview:
Sequences training of the branch predictor, which consists of the BTB and the RAS feeding next-PC generation.
- Takes resolved branch outcomes from EX and detects mispredictions.
- Issues a registered redirect on each mispredict.
- Buffers BTB update writes in a small FIFO and drains them through the single BTB write port.
- Runs a full-BTB invalidation sweep, with RAS clear, on request (fence.i / context switch).

Parameters:
DEPTH, 4, update FIFO entries (power of 2, >=2)
ENTRIES, 64, BTB entries swept on flush (power of 2)
IDXW, $clog2(ENTRIES), sweep index width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
ex_valid  in  1  resolved instruction valid this cycle
ex_ready  out  1  controller can accept ex_valid (FIFO not full, not sweeping)
ex_pc  in  32  PC of resolved instruction
ex_type  in  3  000 none, 001 B_CON, 010 JAL, 011 JALR, 100 CALL, 101 RET, 110 CALL_RET
ex_taken  in  1  actual direction
ex_target  in  32  actual target
ex_pred_hit  in  1  BTB hit carried with the PC
ex_pred_taken  in  1  predicted direction carried with the PC
ex_pred_pc  in  32  predicted next PC carried with the PC
redirect  out  1  mispredict flush pulse
redirect_pc  out  32  correct fetch PC
btb_we  out  1  BTB write request
btb_wready  in  1  BTB write port free
btb_wpc  out  32  write PC
btb_wtype  out  3  write type
btb_wtaken  out  1  write direction
btb_wtarget  out  32  write target
btb_winv  out  1  write is an invalidate (alias removal)
btb_inv_all  out  1  sweep invalidate strobe
btb_inv_idx  out  IDXW  sweep index
ras_clr  out  1  one-cycle RAS clear
flush_req  in  1  request full predictor flush (level)
flush_done  out  1  one-cycle pulse at sweep completion

Behaviour:
- Reset: FSM=IDLE, FIFO empty, sweep index 0. All outputs are 0 except ex_ready=1.
- Accept condition: accepted = ex_valid & ex_ready. With ex_valid & !ex_ready the input is ignored; upstream must hold it.
- Effective prediction:
  - pred_next = ex_pred_hit & (ex_type!=001 | ex_pred_taken) ? ex_pred_pc : ex_pc+4.
  - actual_next = ex_taken ? ex_target : ex_pc+4.
  - All +4 arithmetic is mod 2^32.
- Mispredict = accepted & (pred_next != actual_next).
- Redirect timing: on the next edge, redirect=1 for exactly one cycle and redirect_pc=actual_next (registered, latency 1). Otherwise redirect=0; redirect_pc holds its last value.
- Enqueue rules (on accepted):
  - ex_type!=000: enqueue {pc,type,taken,target,inv=0}.
  - ex_type==000 & ex_pred_hit (alias): enqueue {pc,000,0,0,inv=1}.
  - Otherwise: no enqueue.
- ex_ready = !full & FSM==IDLE.
  - An enqueue and a pop in the same cycle is legal and leaves the count unchanged.
  - When full, ex_ready=0 even if a pop occurs this cycle. No combinational ready-from-pop path.
- Drain: btb_we = !empty & FSM==IDLE. btb_w* come from the FIFO head. Pop on btb_we & btb_wready. FIFO order is preserved.
- FSM IDLE: when flush_req=1, go to CLR.
  - FIFO is emptied at that edge; pending writes are discarded.
  - A same-cycle accepted input still produces redirect but is not enqueued.
- FSM CLR (1 cycle): ras_clr=1, index<=0, then go to SWEEP.
- FSM SWEEP:
  - btb_inv_all=1 and btb_inv_idx=index.
  - Index increments on each cycle with btb_wready=1.
  - When index==ENTRIES-1 and btb_wready=1, go to DONE.
  - btb_we=0 throughout.
- FSM DONE (1 cycle): flush_done=1, then go to IDLE.
  - If flush_req is still high in IDLE, a new flush starts. The requester deasserts on flush_done.
- Outside SWEEP, btb_inv_all=0 and btb_inv_idx=0.
- Reset mid-sweep or mid-drain returns immediately to the reset state; no flush_done is issued.

Test Plan:
- Cold miss on taken JAL: ex_pc=0x100, type=010, taken=1, target=0x200, pred_hit=0 -> next cycle redirect=1, redirect_pc=0x200; btb_we=1 with wpc=0x100, wtarget=0x200, winv=0.
- Correct B_CON prediction: pc=0x40, pred_hit=1, pred_taken=1, pred_pc=0x80, taken=1, target=0x80 -> redirect stays 0; one FIFO write.
- Alias: type=000, pred_hit=1, pred_pc=0x300, pc=0x10 -> redirect_pc=0x14; write with winv=1.
- Backpressure: btb_wready=0, 4 accepted branches -> ex_ready=0 after the 4th; btb_wready=1 -> 4 writes in order; ex_ready returns to 1 the cycle after the first pop.
- Flush with 2 queued entries: flush_req=1 -> ras_clr pulse, 0 BTB writes, btb_inv_idx 0..63; wready low for 3 cycles inside the sweep stretches it to 67 cycles; flush_done after index 63.
- Async reset asserted during SWEEP at idx=20 -> all outputs immediately reset; no flush_done.
